int_ctrl: RTL and testbench
===========================

// Module: int_ctrl
// PURPOSE
//  Interrupt controller arbitrating the five DMG interrupt sources (vblank, stat, timer, serial, joypad)
//  onto the single CPU interrupt line.
//  - Holds IF (FF0F) and IE (FFFF), both CPU-accessible on the shared tri-state data bus.
//  - Picks the highest-priority enabled pending source and runs a req/ack dispatch handshake.
//  - Sits between the peripheral pages (the timer page's int_timer among them) and the CPU core.
// PARAMETERS
//  N_SRC       5      number of interrupt sources; bit 0 = highest priority
//  VEC_BASE    8'h40  vector address of source 0
//  VEC_STRIDE  8      vector spacing between sources
// PORTS
//  boga1mhz     in     1   system clock; all state updates on rising edge
//  reset2       in     1   asynchronous, active-high reset
//  a            in     16  CPU address bus
//  d            inout  8   CPU data bus, tri-state; driven only during a decoded read
//  cpu_wr       in     1   CPU write strobe, sampled on clock edge
//  cpu_rd       in     1   CPU read strobe (combinational drive enable)
//  int_src      in     5   {joypad, serial, timer, stat, vblank} request lines
//  int_ack      in     1   CPU accepts the request currently presented
//  int_req      out    1   interrupt request to CPU
//  int_vector   out    8   vector address of the presented source; valid while int_req=1
//  int_pending  out    1   |(IF & IE & 5'h1F); HALT wake, independent of the FSM
// BEHAVIOUR
//  Reset (async):
//   - IF=5'h00, IE=8'h00, FSM=IDLE, int_req=0, int_vector=8'h00, captured index sel=0, edge-history regs=0.
//  Register access:
//   - Write FF0F: IF <= d[4:0]. Write FFFF: IE <= d[7:0].
//   - Read FF0F: d = {3'b111, IF}. Read FFFF: d = IE. Other addresses: d = 'z.
//  Source capture:
//   - IF[i] is set per CONFIGURATION. A set beats a same-cycle CPU write of 0 and a same-cycle ack clear.
//  Arbitration:
//   - sel = lowest i with IF[i]&IE[i]. int_vector = VEC_BASE + VEC_STRIDE*sel.
//  FSM states: IDLE, REQ, DONE.
//   - IDLE -> REQ when any IF&IE bit is set. sel is frozen on entry; int_req=1 the next cycle (latency 1).
//   - REQ & int_ack: clear IF[sel]; -> DONE.
//   - REQ & !int_ack & (IF[sel]&IE[sel])==0 (CPU cleared it): int_req drops, -> IDLE (cancel). No ack is owed.
//   - REQ: a higher-priority source arriving does NOT re-arbitrate; sel stays frozen until ack or cancel.
//   - DONE: int_req=0 for exactly one cycle, then -> IDLE. A still-pending source is re-requested from IDLE.
//  Illegal handshake:
//   - int_ack outside REQ is ignored; no IF change.
//  Reset mid-dispatch: FSM returns to IDLE, int_req=0 immediately, IF cleared.
//  Reserved IE bits:
//   - IE[7:5] are stored and read back but take no part in arbitration.
// CONFIGURATION
//  INT_CTRL_EDGE_DETECT_EN
//   - defined: IF[i] sets only on a 0->1 transition of int_src[i] (one history flop per source).
//     A held-high source sets IF once.
//   - undefined: IF[i] sets every cycle int_src[i]=1 (level mode). A CPU clear while the source is
//     held high is overridden next cycle.
// STRUCTURE
//  Package int_ctrl_pkg:
//   - enum int_src_e {INT_VBLANK, INT_STAT, INT_TIMER, INT_SERIAL, INT_JOYPAD}
//   - localparams ADDR_IF=16'hFF0F, ADDR_IE=16'hFFFF
//   - FSM state enum int_fsm_e
//  Sub-module int_edge_det: per-source history flop and set pulse; instantiated only under the macro.
//  Priority encoder and register file stay inline.
// TESTING
//  1. Reset, then write IE=8'h04 and pulse int_src[2] -> IF=5'h04, int_req=1 one cycle later,
//     int_vector=8'h50; on int_ack IF=0, int_req low for the DONE cycle.
//  2. IE=8'h1F with int_src[0] and int_src[4] pulsed together -> vector 8'h40. After ack + DONE,
//     second request with vector 8'h60.
//  3. In REQ on sel=2, write FF0F=8'h00 -> int_req drops next cycle, FSM IDLE, no ack required.
//  4. Same cycle: int_ack for sel=2 and a new int_src[2] set -> IF[2] stays 1, re-request after DONE.
//  5. Read FF0F with IF=5'h05 -> d=8'hE5. Read FFFF after writing 8'hFF -> d=8'hFF.
//     Other address -> d floats 'z.
//  6. Assert reset2 while int_req=1 -> int_req=0, IF=0, IE=0 without a clock edge.
//     With EDGE_DETECT_EN, a held-high source after reset sets IF once only.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared types and register addresses for the DMG interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [2:0] {
    INT_VBLANK = 3'd0,
    INT_STAT   = 3'd1,
    INT_TIMER  = 3'd2,
    INT_SERIAL = 3'd3,
    INT_JOYPAD = 3'd4
  } int_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } int_fsm_e;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

endpackage

// File: rtl/int_ctrl_edge_det.sv
// Per-source rising-edge detector: one history flop per source, set pulse on 0->1.
module int_edge_det #(
  parameter int unsigned N_SRC = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  output logic [N_SRC-1:0] set_pulse
);

  logic [N_SRC-1:0] hist_q, hist_d;

  always_comb begin
    hist_d    = src;
    set_pulse = src & ~hist_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= hist_d;
  end

endmodule

// File: rtl/int_ctrl.sv
// DMG interrupt controller: IF/IE registers, fixed-priority arbitration, req/ack dispatch.
// Define INT_CTRL_EDGE_DETECT_EN for edge-triggered IF capture (default: level).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC      = 5,
  parameter logic [7:0]  VEC_BASE   = 8'h40,
  parameter int unsigned VEC_STRIDE = 8
) (
  input  logic             boga1mhz,
  input  logic             reset2,
  input  logic [15:0]      a,
  inout  wire  [7:0]       d,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  input  logic [N_SRC-1:0] int_src,
  input  logic             int_ack,
  output logic             int_req,
  output logic [7:0]       int_vector,
  output logic             int_pending
);

  localparam int unsigned SEL_W = $clog2(N_SRC);

  int_fsm_e         state_q, state_d;
  logic [N_SRC-1:0] if_q, if_d;
  logic [7:0]       ie_q, ie_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic [N_SRC-1:0] set_pulse;
  logic [N_SRC-1:0] active;
  logic [SEL_W-1:0] pe_sel;
  logic             rd_en;
  logic [7:0]       rd_data;

`ifdef INT_CTRL_EDGE_DETECT_EN
  int_edge_det #(.N_SRC(N_SRC)) u_edge_det (
    .clk       (boga1mhz),
    .rst       (reset2),
    .src       (int_src),
    .set_pulse (set_pulse)
  );
`else
  assign set_pulse = int_src;
`endif

  assign active      = if_q & ie_q[N_SRC-1:0];
  assign int_pending = |active;

  always_comb begin
    logic found;
    pe_sel = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (active[i] && !found) begin
        pe_sel = SEL_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rd_en   = cpu_rd && ((a == ADDR_IF) || (a == ADDR_IE));
    rd_data = (a == ADDR_IF) ? {{(8-N_SRC){1'b1}}, if_q} : ie_q;
  end

  assign d = rd_en ? rd_data : 8'bz;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if_d    = if_q;
    ie_d    = ie_q;

    if (cpu_wr && (a == ADDR_IF)) if_d = d[N_SRC-1:0];
    if (cpu_wr && (a == ADDR_IE)) ie_d = d;

    unique case (state_q)
      ST_IDLE: begin
        if (int_pending) begin
          state_d = ST_REQ;
          sel_d   = pe_sel;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          if_d[sel_q] = 1'b0;
          state_d     = ST_DONE;
        end else if (!active[sel_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Source sets are applied last so they win over CPU and ack clears.
    if_d = if_d | set_pulse;
  end

  always_ff @(posedge boga1mhz or posedge reset2) begin
    if (reset2) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      if_q    <= '0;
      ie_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if_q    <= if_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    int_req    = (state_q == ST_REQ);
    int_vector = int_req ? (VEC_BASE + 8'(VEC_STRIDE * sel_q)) : 8'h00;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expected vectors queued at stimulus, popped at each request.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [4:0]  int_src = '0;
  logic        int_ack = 1'b0;
  logic        int_req;
  logic [7:0]  int_vector;
  logic        int_pending;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dout = '0;
  wire  [7:0]  d_bus;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  rd_val;

  assign d_bus = tb_oe ? tb_dout : 8'bz;

  int_ctrl #(.N_SRC(5), .VEC_BASE(8'h40), .VEC_STRIDE(8)) dut (
    .boga1mhz    (clk),
    .reset2      (rst),
    .a           (a),
    .d           (d_bus),
    .cpu_wr      (cpu_wr),
    .cpu_rd      (cpu_rd),
    .int_src     (int_src),
    .int_ack     (int_ack),
    .int_req     (int_req),
    .int_vector  (int_vector),
    .int_pending (int_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    a = addr; tb_dout = data; tb_oe = 1'b1; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data);
    a = addr; cpu_rd = 1'b1;
    #2;
    data = d_bus;
    cpu_rd = 1'b0;
  endtask

  task automatic pulse_src(input logic [4:0] mask);
    int_src = mask;
    tick();
    int_src = '0;
  endtask

  task automatic ack_once();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    logic [7:0] exp_v;
    while (!int_req && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_req"}, 32'(int_req), 32'd1);
    if (int_req) begin
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      check_eq({tag, "_vec"}, 32'(int_vector), 32'(exp_v));
    end
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_req", 32'(int_req), 32'd0);
    check_eq("rst_vec", 32'(int_vector), 32'h00);
    check_eq("rst_pend", 32'(int_pending), 32'd0);
    cpu_read(ADDR_IF, rd_val);
    check_eq("rst_if", 32'(rd_val), 32'hE0);
    cpu_read(ADDR_IE, rd_val);
    check_eq("rst_ie", 32'(rd_val), 32'h00);
    rst = 1'b0;
    tick();

    // 1: timer only
    cpu_write(ADDR_IE, 8'h04);
    sb_q.push_back(8'h50);
    pulse_src(5'h04);
    cpu_read(ADDR_IF, rd_val);
    check_eq("t1_if", 32'(rd_val), 32'hE4);
    check_eq("t1_lat0", 32'(int_req), 32'd0);
    tick();
    check_eq("t1_lat1", 32'(int_req), 32'd1);
    wait_req("t1");
    ack_once();
    check_eq("t1_done", 32'(int_req), 32'd0);
    cpu_read(ADDR_IF, rd_val);
    check_eq("t1_if_clr", 32'(rd_val), 32'hE0);
    tick();
    check_eq("t1_idle", 32'(int_req), 32'd0);

    // 2: vblank + joypad together, priority order
    cpu_write(ADDR_IE, 8'h1F);
    sb_q.push_back(8'h40);
    sb_q.push_back(8'h60);
    pulse_src(5'h11);
    wait_req("t2a");
    ack_once();
    check_eq("t2_done", 32'(int_req), 32'd0);
    wait_req("t2b");
    ack_once();
    tick();

    // 3: CPU cancels while in REQ
    sb_q.push_back(8'h50);
    pulse_src(5'h04);
    wait_req("t3");
    cpu_write(ADDR_IF, 8'h00);
    check_eq("t3_hold", 32'(int_req), 32'd1);
    tick();
    check_eq("t3_cancel", 32'(int_req), 32'd0);
    check_eq("t3_vec0", 32'(int_vector), 32'h00);
    repeat (3) tick();
    check_eq("t3_idle", 32'(int_req), 32'd0);

    // 4: ack and new set of the same source in one cycle
    sb_q.push_back(8'h50);
    pulse_src(5'h04);
    wait_req("t4a");
    int_ack = 1'b1; int_src = 5'h04;
    tick();
    int_ack = 1'b0; int_src = '0;
    cpu_read(ADDR_IF, rd_val);
    check_eq("t4_if_kept", 32'(rd_val), 32'hE4);
    check_eq("t4_done", 32'(int_req), 32'd0);
    sb_q.push_back(8'h50);
    wait_req("t4b");
    ack_once();
    tick();

    // 5: register reads, illegal ack, reserved IE bits, floating bus
    cpu_write(ADDR_IE, 8'h00);
    cpu_write(ADDR_IF, 8'h05);
    cpu_read(ADDR_IF, rd_val);
    check_eq("t5_if", 32'(rd_val), 32'hE5);
    check_eq("t5_pend0", 32'(int_pending), 32'd0);
    ack_once();
    cpu_read(ADDR_IF, rd_val);
    check_eq("t5_ack_ign", 32'(rd_val), 32'hE5);
    check_eq("t5_noreq", 32'(int_req), 32'd0);
    sb_q.push_back(8'h40);
    sb_q.push_back(8'h50);
    cpu_write(ADDR_IE, 8'hFF);
    cpu_read(ADDR_IE, rd_val);
    check_eq("t5_ie", 32'(rd_val), 32'hFF);
    check_eq("t5_pend1", 32'(int_pending), 32'd1);
    a = 16'hFF10; cpu_rd = 1'b1;
    #1;
    check_eq("t5_float", 32'(d_bus === 8'bz), 32'd1);
    cpu_rd = 1'b0;
    wait_req("t5a");
    ack_once();
    wait_req("t5b");
    ack_once();
    tick();

    // 6: async reset mid-dispatch
    cpu_write(ADDR_IE, 8'h04);
    sb_q.push_back(8'h50);
    pulse_src(5'h04);
    wait_req("t6");
    #2 rst = 1'b1;
    #1;
    check_eq("t6_req", 32'(int_req), 32'd0);
    cpu_read(ADDR_IF, rd_val);
    check_eq("t6_if", 32'(rd_val), 32'hE0);
    cpu_read(ADDR_IE, rd_val);
    check_eq("t6_ie", 32'(rd_val), 32'h00);
    rst = 1'b0;
    tick();

    // Held-high source after reset
    int_src = 5'h04;
    repeat (3) tick();
    cpu_read(ADDR_IF, rd_val);
    check_eq("t6_held_set", 32'(rd_val), 32'hE4);
    cpu_write(ADDR_IF, 8'h00);
    repeat (2) tick();
    cpu_read(ADDR_IF, rd_val);
`ifdef INT_CTRL_EDGE_DETECT_EN
    check_eq("t6_held_once", 32'(rd_val), 32'hE0);
`else
    check_eq("t6_held_level", 32'(rd_val), 32'hE4);
`endif
    int_src = '0;
    tick();
    check_eq("t6_noreq", 32'(int_req), 32'd0);
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
